// File: rtl/adam_mem_dift_obi_if.sv
// OBI request/response bundle for the DIFT direct-RAM path: data plus one tag bit per byte.
interface adam_mem_dift_obi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we_tag;
  logic                  wdata_tag;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NB-1:0]         rdata_tag;

  modport master (
    output req, addr, we, be, wdata, we_tag, wdata_tag,
    input  gnt, rvalid, rdata, rdata_tag
  );

  modport slave (
    input  req, addr, we, be, wdata, we_tag, wdata_tag,
    output gnt, rvalid, rdata, rdata_tag
  );
endinterface

// File: rtl/adam_mem_dift_obi.sv
// DIFT RAM responder: byte-lane data RAM with a parallel per-byte tag RAM,
// scrubbed to TAG_INIT after every reset before requests are granted.

// One byte lane: data byte array, its tag bit array, and the registered read port.
module adam_mem_dift_obi_lane #(
  parameter int   WORDS    = 16,
  parameter int   IDX_W    = 4,
  parameter logic TAG_INIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             clr_i,
  input  logic [7:0]       wdata_i,
  input  logic             tag_we_i,
  input  logic             tag_i,
  output logic [7:0]       rdata_o,
  output logic             rtag_o
);
  logic [7:0] data_mem [WORDS];
  logic       tag_mem  [WORDS];
  logic [7:0] rdata_q;
  logic       rtag_q;

  always_ff @(posedge clk_i) begin
    if (wr_i) data_mem[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (tag_we_i) tag_mem[idx_i] <= tag_i;
  end

  // Read samples the array before any same-edge write; write responses return zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      rtag_q  <= 1'b0;
    end else if (rd_i) begin
      rdata_q <= data_mem[idx_i];
      rtag_q  <= tag_mem[idx_i];
    end else if (clr_i) begin
      rdata_q <= '0;
      rtag_q  <= 1'b0;
    end
  end

  assign rdata_o = rdata_q;
  assign rtag_o  = rtag_q;
endmodule

module adam_mem_dift_obi #(
  parameter int   SIZE       = 65536,
  parameter int   ADDR_WIDTH = 32,
  parameter int   DATA_WIDTH = 32,
  parameter logic TAG_INIT   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  adam_mem_dift_obi_if.slave   obi,
  output logic                 init_done_o
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int WORDS     = SIZE / 4;
  localparam int AW        = $clog2(SIZE);
  localparam int IDX_W     = AW - 2;

  typedef enum logic {SCRUB, READY} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   cnt_q, cnt_d;
  logic                               rvalid_q, rvalid_d;
  logic                               gnt;
  logic                               scrub_we;
  logic                               acc_rd, acc_wr;
  logic [IDX_W-1:0]                   idx;
  logic                               tag_val;
  logic [NUM_LANES-1:0][7:0]          rdata_lane;
  logic [NUM_LANES-1:0][7:0]          wdata_lane;
  logic [NUM_LANES-1:0]               rtag_lane;
  logic                               addr_unused;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SCRUB;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scrub_we = 1'b0;
    gnt      = 1'b0;
    case (state_q)
      SCRUB: begin
        scrub_we = ~rst_i;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(WORDS - 1)) state_d = READY;
      end
      READY: gnt = obi.req;
      default: state_d = SCRUB;
    endcase
  end

  // Nothing touches the arrays in a reset cycle, even if a stale grant is showing.
  assign acc_rd   = gnt & ~obi.we & ~rst_i;
  assign acc_wr   = gnt &  obi.we & ~rst_i;
  assign rvalid_d = gnt;

  assign idx     = (state_q == SCRUB) ? cnt_q : obi.addr[AW-1:2];
  assign tag_val = (state_q == SCRUB) ? TAG_INIT : obi.wdata_tag;

  assign wdata_lane  = obi.wdata;
  assign addr_unused = ^{obi.addr[1:0], obi.addr[ADDR_WIDTH-1:AW]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    adam_mem_dift_obi_lane #(
      .WORDS    (WORDS),
      .IDX_W    (IDX_W),
      .TAG_INIT (TAG_INIT)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .idx_i    (idx),
      .rd_i     (acc_rd),
      .wr_i     (acc_wr & obi.be[i]),
      .clr_i    (acc_wr),
      .wdata_i  (wdata_lane[i]),
      .tag_we_i (scrub_we | (acc_wr & obi.be[i] & obi.we_tag)),
      .tag_i    (tag_val),
      .rdata_o  (rdata_lane[i]),
      .rtag_o   (rtag_lane[i])
    );
  end

  assign obi.gnt       = gnt;
  assign obi.rvalid    = rvalid_q;
  assign obi.rdata     = rdata_lane;
  assign obi.rdata_tag = rtag_lane;
  assign init_done_o   = (state_q == READY);
endmodule

// File: tb/tb_adam_mem_dift_obi.sv
// Directed bench for adam_mem_dift_obi at SIZE=64: scrub timing, table-driven
// read/write vectors, aliasing, back-to-back traffic and reset mid-flight.
module tb_adam_mem_dift_obi;
  logic clk;
  logic rst;
  logic init_done;
  int   n_chk  = 0;
  int   n_pass = 0;

  adam_mem_dift_obi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();

  adam_mem_dift_obi #(
    .SIZE(64), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_INIT(1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .obi         (obi),
    .init_done_o (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we_tag;
    logic        wtag;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_rtag;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_bus();
    obi.req = 1'b0; obi.we = 1'b0; obi.addr = '0; obi.be = '0;
    obi.wdata = '0; obi.we_tag = 1'b0; obi.wdata_tag = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    obi.req = 1'b1; obi.we = v.we; obi.addr = v.addr; obi.be = v.be;
    obi.wdata = v.wdata; obi.we_tag = v.we_tag; obi.wdata_tag = v.wtag;
  endtask

  // Single transaction launched on a negedge; response sampled on the next negedge.
  task automatic xact(input string nm, input vec_t v, input logic chk_data);
    drive(v);
    #1 chk({nm, " gnt"}, 32'(obi.gnt), 32'd1);
    @(negedge clk);
    idle_bus();
    chk({nm, " rvalid"}, 32'(obi.rvalid), 32'd1);
    if (chk_data) chk({nm, " rdata"}, obi.rdata, v.exp_rdata);
    chk({nm, " rtag"}, 32'(obi.rdata_tag), 32'(v.exp_rtag));
  endtask

  function automatic vec_t rd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    vec_t v;
    v = '{1'b0, a, 4'h0, 32'h0, 1'b0, 1'b0, d, t};
    return v;
  endfunction

  function automatic vec_t wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                              input logic wt, input logic t);
    vec_t v;
    v = '{1'b1, a, b, d, wt, t, 32'h0, 4'h0};
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int cyc;
    tbl[0]  = wr(32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
    tbl[1]  = rd(32'h10, 32'hDEADBEEF, 4'b1111);
    tbl[2]  = wr(32'h10, 4'b0100, 32'h00AA0000, 1'b1, 1'b0);
    tbl[3]  = rd(32'h10, 32'hDEAABEEF, 4'b1011);
    tbl[4]  = wr(32'h10, 4'hF, 32'h12345678, 1'b0, 1'b1);
    tbl[5]  = rd(32'h10, 32'h12345678, 4'b1011);
    tbl[6]  = wr(32'h44, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
    tbl[7]  = rd(32'h04, 32'hCAFEF00D, 4'b1111);
    tbl[8]  = wr(32'h08, 4'hF, 32'h01020304, 1'b1, 1'b0);
    tbl[9]  = wr(32'h08, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
    tbl[10] = rd(32'h08, 32'h01020304, 4'b0000);
    tbl[11] = rd(32'h13, 32'h12345678, 4'b1011);
    tbl[12] = wr(32'h3C, 4'b1001, 32'hA1B2C3D4, 1'b1, 1'b1);
    tbl[13] = rd(32'h3C, 32'hA1000000 | 32'h000000D4 | 32'h00FFFF00 & 32'h0, 4'b1001);

    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset rvalid", 32'(obi.rvalid), 32'd0);
    chk("reset rdata", obi.rdata, 32'd0);
    chk("reset rtag", 32'(obi.rdata_tag), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);

    // Scrub: a pending request must be ignored for 16 cycles.
    rst = 1'b0;
    obi.req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (obi.gnt !== 1'b0 || init_done !== 1'b0 || obi.rvalid !== 1'b0)
        chk($sformatf("scrub cyc%0d gnt/done/rvalid", c),
            {29'd0, obi.gnt, init_done, obi.rvalid}, 32'd0);
      @(negedge clk);
    end
    chk("scrub init_done at 16", 32'(init_done), 32'd1);
    idle_bus();

    // Word 15 must have its lower bytes known for the tbl[13] data compare.
    xact("pre3C", wr(32'h3C, 4'hF, 32'h00000000, 1'b0, 1'b0), 1'b1);

    for (int w = 0; w < 16; w++)
      xact($sformatf("scrubrd w%0d", w), rd(32'(w * 4), 32'h0, 4'b0000), 1'b0);

    for (int i = 0; i < 14; i++)
      xact($sformatf("vec%0d", i), tbl[i], 1'b1);

    // Idle: rvalid drops, data holds.
    @(negedge clk);
    chk("idle rvalid", 32'(obi.rvalid), 32'd0);
    chk("idle rdata hold", obi.rdata, 32'hA10000D4);
    chk("idle rtag hold", 32'(obi.rdata_tag), 32'b1001);

    // Back-to-back read / write / read of the same word.
    drive(rd(32'h10, 32'h0, 4'h0));
    @(negedge clk);
    chk("b2b r1 rvalid", 32'(obi.rvalid), 32'd1);
    chk("b2b r1 rdata", obi.rdata, 32'h12345678);
    drive(wr(32'h10, 4'hF, 32'h55667788, 1'b1, 1'b0));
    @(negedge clk);
    chk("b2b w rvalid", 32'(obi.rvalid), 32'd1);
    chk("b2b w rdata", obi.rdata, 32'h0);
    drive(rd(32'h10, 32'h0, 4'h0));
    @(negedge clk);
    idle_bus();
    chk("b2b r2 rvalid", 32'(obi.rvalid), 32'd1);
    chk("b2b r2 rdata", obi.rdata, 32'h55667788);
    chk("b2b r2 rtag", 32'(obi.rdata_tag), 32'b0000);
    @(negedge clk);
    chk("b2b tail rvalid", 32'(obi.rvalid), 32'd0);

    // Reset with a read in flight: response dropped, scrub reruns, data kept.
    drive(rd(32'h04, 32'h0, 4'h0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst rvalid", 32'(obi.rvalid), 32'd0);
    chk("midrst init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    cyc = 0;
    while (init_done !== 1'b1 && cyc < 40) begin
      #1 if (obi.gnt !== 1'b0) chk("midrst scrub gnt", 32'(obi.gnt), 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("midrst scrub cycles", 32'(cyc), 32'd16);
    idle_bus();
    xact("midrst rd04", rd(32'h04, 32'hCAFEF00D, 4'b0000), 1'b1);
    xact("midrst rd10", rd(32'h10, 32'h55667788, 4'b0000), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
